// File: rtl/game_vga_timing.sv
// Raster timing generator: pixel strobe, h/v counters, syncs, coordinates and frame events.
// Outputs decode the counter registers combinationally (zero added latency); free-running, no back-pressure.
module game_vga_timing #(
  parameter int clk_mhz         = 50,
  parameter int pixel_mhz       = 25,
  parameter int screen_width    = 640,
  parameter int screen_height   = 480,
  parameter int h_front         = 16,
  parameter int h_sync          = 96,
  parameter int h_back          = 48,
  parameter int v_front         = 10,
  parameter int v_sync          = 2,
  parameter int v_back          = 33,
  parameter int sync_active_low = 1,
  parameter int w_x             = $clog2(screen_width),
  parameter int w_y             = $clog2(screen_height)
) (
  input  logic           clk,
  input  logic           rst,
  output logic           pixel_strobe,
  output logic           hsync,
  output logic           vsync,
  output logic           display_on,
  output logic [w_x-1:0] x,
  output logic [w_y-1:0] y,
  output logic           end_of_line,
  output logic           end_of_frame,
  output logic [7:0]     frame_count
);

  localparam int RATIO    = clk_mhz / pixel_mhz;
  localparam int H_TOTAL  = screen_width + h_front + h_sync + h_back;
  localparam int V_TOTAL  = screen_height + v_front + v_sync + v_back;
  localparam int DIV_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int H_W      = $clog2(H_TOTAL);
  localparam int V_W      = $clog2(V_TOTAL);
  localparam int HS_START = screen_width + h_front;
  localparam int HS_END   = screen_width + h_front + h_sync - 1;
  localparam int VS_START = screen_height + v_front;
  localparam int VS_END   = screen_height + v_front + v_sync - 1;
  localparam logic SYNC_ON = (sync_active_low == 0);

  if ((clk_mhz % pixel_mhz) != 0) begin : g_bad_ratio
    $error("game_vga_timing: clk_mhz must be an integer multiple of pixel_mhz");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [H_W-1:0]   h_cnt;
  logic [V_W-1:0]   v_cnt;
  logic             h_active;
  logic             v_active;
  logic             h_in_sync;
  logic             v_in_sync;

  // With RATIO == 1 the divider sits at 0 == RATIO-1, so the strobe is constant.
  assign pixel_strobe = (div_cnt == DIV_W'(RATIO - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_count <= '0;
    end else begin
      div_cnt <= pixel_strobe ? '0 : div_cnt + DIV_W'(1);
      if (pixel_strobe) begin
        if (h_cnt == H_W'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_W'(V_TOTAL - 1)) ? '0 : v_cnt + V_W'(1);
        end else begin
          h_cnt <= h_cnt + H_W'(1);
        end
      end
      if (end_of_frame) frame_count <= frame_count + 8'd1;
    end
  end

  assign h_active  = (h_cnt < H_W'(screen_width));
  assign v_active  = (v_cnt < V_W'(screen_height));
  assign h_in_sync = (h_cnt >= H_W'(HS_START)) && (h_cnt <= H_W'(HS_END));
  assign v_in_sync = (v_cnt >= V_W'(VS_START)) && (v_cnt <= V_W'(VS_END));

  assign display_on   = h_active && v_active;
  assign x            = h_active ? w_x'(h_cnt) : '0;
  assign y            = v_active ? w_y'(v_cnt) : '0;
  assign hsync        = h_in_sync ? SYNC_ON : ~SYNC_ON;
  assign vsync        = v_in_sync ? SYNC_ON : ~SYNC_ON;
  assign end_of_line  = pixel_strobe && (h_cnt == H_W'(H_TOTAL - 1));
  assign end_of_frame = end_of_line && (v_cnt == V_W'(V_TOTAL - 1));

endmodule

// File: tb/tb_game_vga_timing.sv
// Directed bench: instance A uses a 24x13 raster at RATIO 2, instance B a 7x5 raster at RATIO 1.
module tb_game_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       strobe_a, hsync_a, vsync_a, disp_a, eol_a, eof_a;
  logic [3:0] x_a;
  logic [2:0] y_a;
  logic [7:0] fc_a;
  logic       strobe_b, hsync_b, vsync_b, disp_b, eol_b, eof_b;
  logic [1:0] x_b;
  logic [0:0] y_b;
  logic [7:0] fc_b;

  // A: RATIO 2, H_TOTAL 24 (hsync h 18..21), V_TOTAL 13 (vsync v 9..10), 624 clks/frame
  game_vga_timing #(
    .clk_mhz(50), .pixel_mhz(25), .screen_width(16), .screen_height(8),
    .h_front(2), .h_sync(4), .h_back(2), .v_front(1), .v_sync(2), .v_back(2),
    .sync_active_low(1)
  ) dut_a (
    .clk(clk), .rst(rst_a), .pixel_strobe(strobe_a), .hsync(hsync_a), .vsync(vsync_a),
    .display_on(disp_a), .x(x_a), .y(y_a), .end_of_line(eol_a), .end_of_frame(eof_a),
    .frame_count(fc_a)
  );

  // B: RATIO 1, H_TOTAL 7 (hsync h 5), V_TOTAL 5 (vsync v 3), 35 clks/frame
  game_vga_timing #(
    .clk_mhz(25), .pixel_mhz(25), .screen_width(4), .screen_height(2),
    .h_front(1), .h_sync(1), .h_back(1), .v_front(1), .v_sync(1), .v_back(1),
    .sync_active_low(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .pixel_strobe(strobe_b), .hsync(hsync_b), .vsync(vsync_b),
    .display_on(disp_b), .x(x_b), .y(y_b), .end_of_line(eol_b), .end_of_frame(eof_b),
    .frame_count(fc_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  initial begin
    int n_strobe, n_disp, n_hs, n_vs, n_eol, n_eof, t_eof, fc_at_eof;
    int t_dfall, t_hs, t_vs, n_nostrobe;
    n_strobe = 0; n_disp = 0; n_hs = 0; n_vs = 0; n_eol = 0; n_eof = 0;
    t_eof = -1; fc_at_eof = -1; t_dfall = -1; t_hs = -1; t_vs = -1; n_nostrobe = 0;

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_a_strobe", int'(strobe_a), 0);
    check("rst_a_disp", int'(disp_a), 1);
    check("rst_a_hsync", int'(hsync_a), 1);
    check("rst_a_vsync", int'(vsync_a), 1);
    check("rst_a_eol", int'(eol_a), 0);
    check("rst_b_strobe", int'(strobe_b), 1);
    check("rst_b_fc", int'(fc_b), 0);

    // Instance A, one full frame; t counts clocks since reset release.
    rst_a = 1'b0;
    for (int t = 0; t < 624; t++) begin
      if (strobe_a) n_strobe++;
      if (disp_a) n_disp++;
      if (!hsync_a) n_hs++;
      if (!vsync_a) n_vs++;
      if (eol_a) n_eol++;
      if (eof_a) begin n_eof++; t_eof = t; fc_at_eof = int'(fc_a); end
      if (!disp_a && t_dfall < 0) t_dfall = t;
      if (!hsync_a && t_hs < 0) t_hs = t;
      if (!vsync_a && t_vs < 0) t_vs = t;
      case (t)
        0: begin
          check("a_t0_strobe", int'(strobe_a), 0);
          check("a_t0_x", int'(x_a), 0);
          check("a_t0_y", int'(y_a), 0);
          check("a_t0_disp", int'(disp_a), 1);
          check("a_t0_hsync", int'(hsync_a), 1);
          check("a_t0_vsync", int'(vsync_a), 1);
          check("a_t0_fc", int'(fc_a), 0);
        end
        1: begin
          check("a_t1_strobe", int'(strobe_a), 1);
          check("a_t1_x", int'(x_a), 0);
        end
        2: begin
          check("a_t2_strobe", int'(strobe_a), 0);
          check("a_t2_x", int'(x_a), 1);
        end
        31: check("a_h15_x", int'(x_a), 15);
        32: begin
          check("a_h16_x", int'(x_a), 0);
          check("a_h16_disp", int'(disp_a), 0);
        end
        40: begin
          check("a_h20_hsync", int'(hsync_a), 0);
          check("a_h20_x", int'(x_a), 0);
        end
        47: begin
          check("a_h23_eol", int'(eol_a), 1);
          check("a_h23_eof", int'(eof_a), 0);
        end
        366: begin
          check("a_last_px_x", int'(x_a), 15);
          check("a_last_px_y", int'(y_a), 7);
          check("a_last_px_disp", int'(disp_a), 1);
        end
        384: begin
          check("a_v8_y", int'(y_a), 0);
          check("a_v8_disp", int'(disp_a), 0);
        end
        432: check("a_v9_vsync", int'(vsync_a), 0);
        527: check("a_v10_vsync", int'(vsync_a), 0);
        528: check("a_v11_vsync", int'(vsync_a), 1);
        default: ;
      endcase
      @(negedge clk);
    end
    check("a_n_strobe", n_strobe, 312);
    check("a_n_disp", n_disp, 256);
    check("a_n_hsync_low", n_hs, 104);
    check("a_n_vsync_low", n_vs, 96);
    check("a_n_eol", n_eol, 13);
    check("a_n_eof", n_eof, 1);
    check("a_t_eof", t_eof, 623);
    check("a_fc_at_eof", fc_at_eof, 0);
    check("a_t_disp_fall", t_dfall, 32);
    check("a_t_hsync_fall", t_hs, 36);
    check("a_t_vsync_fall", t_vs, 432);
    check("a_frame1_fc", int'(fc_a), 1);
    check("a_frame1_disp", int'(disp_a), 1);
    check("a_frame1_eof", int'(eof_a), 0);

    // Move to h=20, v=9 with strobe high (t=1097), then reset for one clock.
    repeat (473) @(negedge clk);
    check("a_pre_rst_hsync", int'(hsync_a), 0);
    check("a_pre_rst_vsync", int'(vsync_a), 0);
    check("a_pre_rst_strobe", int'(strobe_a), 1);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("a_post_rst_hsync", int'(hsync_a), 1);
    check("a_post_rst_vsync", int'(vsync_a), 1);
    check("a_post_rst_fc", int'(fc_a), 0);
    check("a_post_rst_x", int'(x_a), 0);
    check("a_post_rst_y", int'(y_a), 0);
    check("a_post_rst_disp", int'(disp_a), 1);
    check("a_post_rst_strobe", int'(strobe_a), 0);
    @(negedge clk);
    check("a_rel_t1_strobe", int'(strobe_a), 1);
    @(negedge clk);
    check("a_rel_t2_x", int'(x_a), 1);

    // Instance B, 256 frames with a constant pixel strobe.
    n_eol = 0; n_eof = 0;
    rst_b = 1'b0;
    for (int t = 0; t < 8960; t++) begin
      if (!strobe_b) n_nostrobe++;
      if (eol_b) n_eol++;
      if (eof_b) n_eof++;
      case (t)
        0: begin
          check("b_t0_x", int'(x_b), 0);
          check("b_t0_disp", int'(disp_b), 1);
          check("b_t0_fc", int'(fc_b), 0);
        end
        1: check("b_t1_x", int'(x_b), 1);
        4: check("b_h4_disp", int'(disp_b), 0);
        5: check("b_h5_hsync", int'(hsync_b), 0);
        6: begin
          check("b_h6_eol", int'(eol_b), 1);
          check("b_h6_hsync", int'(hsync_b), 1);
        end
        7: begin
          check("b_v1_y", int'(y_b), 1);
          check("b_v1_disp", int'(disp_b), 1);
        end
        14: check("b_v2_disp", int'(disp_b), 0);
        21: check("b_v3_vsync", int'(vsync_b), 0);
        28: check("b_v4_vsync", int'(vsync_b), 1);
        34: check("b_t34_eof", int'(eof_b), 1);
        35: check("b_t35_fc", int'(fc_b), 1);
        8959: begin
          check("b_last_fc", int'(fc_b), 255);
          check("b_last_eof", int'(eof_b), 1);
        end
        default: ;
      endcase
      @(negedge clk);
    end
    check("b_n_nostrobe", n_nostrobe, 0);
    check("b_n_eol", n_eol, 1280);
    check("b_n_eof", n_eof, 256);
    check("b_fc_wrap", int'(fc_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
